// File: rtl/tof_pkg.sv
// Shared constants, state encoding and bus-slicing helper for the time-of-flight collector.
package tof_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ARMED  = 2'd1;
    localparam state_t OUTPUT = 2'd2;

    localparam int TS_W_DEF    = 32;
    localparam int TIMEOUT_DEF = 60000;

    // LSB of channel i inside a flat bus of w-bit lanes: bus[ch_lsb(i, w) +: w]
    function automatic int ch_lsb(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/tof_channel.sv
// Per-channel rise detector, first-hit latch and time-of-flight subtractor.
// Hit/tof register one cycle after the rising edge; no backpressure (pure capture).
module tof_channel
    import tof_pkg::*;
#(
    parameter int TS_W = TS_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ch_valid_i,
    input  logic [TS_W-1:0] stamp_i,
    input  logic [TS_W-1:0] t0_i,
    input  logic            clear_i,
    input  logic            capture_en_i,
    output logic            rise_o,
    output logic            hit_o,
    output logic [TS_W-1:0] tof_o
);

    logic            valid_d_q;
    logic            hit_q, hit_d;
    logic [TS_W-1:0] tof_q, tof_d;

    assign rise_o = ch_valid_i & ~valid_d_q;
    assign hit_o  = hit_q;
    assign tof_o  = tof_q;

    // Only the first rise after arming is kept; the subtraction wraps with the counter.
    always_comb begin
        hit_d = hit_q;
        tof_d = tof_q;
        if (clear_i) begin
            hit_d = 1'b0;
            tof_d = '0;
        end else if (capture_en_i && rise_o && !hit_q) begin
            hit_d = 1'b1;
            tof_d = stamp_i - t0_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_d_q <= 1'b0;
            hit_q     <= 1'b0;
            tof_q     <= '0;
        end else begin
            valid_d_q <= ch_valid_i;
            hit_q     <= hit_d;
            tof_q     <= tof_d;
        end
    end

endmodule

// File: rtl/tof_collector.sv
// Collects first hit per receiver after each emission and emits one time-of-flight frame.
// Frame valid on the edge of the closing hit/timeout; held until frame_ready, emissions meanwhile flag overrun.
module tof_collector
    import tof_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TS_W    = TS_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   tx_start_i,
    input  logic [TS_W-1:0]        time_cnt_i,
    input  logic [NUM_CH-1:0]      ch_valid_i,
    input  logic [NUM_CH*TS_W-1:0] ch_stamp_i,
    output logic                   frame_valid_o,
    input  logic                   frame_ready_i,
    output logic [NUM_CH*TS_W-1:0] frame_tof_o,
    output logic [NUM_CH-1:0]      frame_hit_mask_o,
    output logic                   frame_timeout_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    state_t            state_q, state_d;
    logic [TS_W-1:0]   t0_q, t0_d;
    logic              frame_valid_q, frame_valid_d;
    logic              frame_timeout_q, frame_timeout_d;
    logic              overrun_q, overrun_d;

    logic [NUM_CH-1:0] rise, hit;
    logic              arm, capture_en, all_hit, timed_out;
    logic [TS_W-1:0]   elapsed;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tof_channel #(.TS_W(TS_W)) u_ch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .ch_valid_i   (ch_valid_i[g]),
            .stamp_i      (ch_stamp_i[ch_lsb(g, TS_W) +: TS_W]),
            .t0_i         (t0_q),
            .clear_i      (arm),
            .capture_en_i (capture_en),
            .rise_o       (rise[g]),
            .hit_o        (hit[g]),
            .tof_o        (frame_tof_o[ch_lsb(g, TS_W) +: TS_W])
        );
    end

    // A hit registering this cycle counts towards closing the frame on the same edge.
    assign all_hit   = &(hit | rise);
    assign elapsed   = time_cnt_i - t0_q;
    assign timed_out = (elapsed >= TS_W'(TIMEOUT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_start_i)              state_d = ARMED;
            ARMED:   if (all_hit || timed_out)    state_d = OUTPUT;
            OUTPUT:  if (frame_ready_i)           state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    always_comb begin
        arm             = (state_q == IDLE) && tx_start_i;
        capture_en      = (state_q == ARMED);
        busy_o          = (state_q != IDLE);
        t0_d            = arm ? time_cnt_i : t0_q;
        overrun_d       = tx_start_i && (state_q != IDLE);
        frame_valid_d   = frame_valid_q;
        frame_timeout_d = frame_timeout_q;
        if (arm) begin
            frame_timeout_d = 1'b0;
        end else if (capture_en && (all_hit || timed_out)) begin
            frame_valid_d   = 1'b1;
            frame_timeout_d = !all_hit;
        end else if ((state_q == OUTPUT) && frame_ready_i) begin
            frame_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            t0_q            <= '0;
            frame_valid_q   <= 1'b0;
            frame_timeout_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            t0_q            <= t0_d;
            frame_valid_q   <= frame_valid_d;
            frame_timeout_q <= frame_timeout_d;
            overrun_q       <= overrun_d;
        end
    end

    assign frame_valid_o    = frame_valid_q;
    assign frame_timeout_o  = frame_timeout_q;
    assign frame_hit_mask_o = hit;
    assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_tof_collector.sv
// Directed scenarios plus randomized traffic checked cycle-by-cycle against a frame-level reference model.
module tb_tof_collector;

    localparam int NUM_CH  = 4;
    localparam int TS_W    = 32;
    localparam int TIMEOUT = 60000;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b1;
    logic                   tx_start_i = 1'b0;
    logic [TS_W-1:0]        time_cnt_i = '0;
    logic [NUM_CH-1:0]      ch_valid_i = '0;
    logic [NUM_CH*TS_W-1:0] ch_stamp_i = '0;
    logic                   frame_ready_i = 1'b0;
    logic                   frame_valid_o;
    logic [NUM_CH*TS_W-1:0] frame_tof_o;
    logic [NUM_CH-1:0]      frame_hit_mask_o;
    logic                   frame_timeout_o;
    logic                   busy_o;
    logic                   overrun_o;

    always #5 clk_i = ~clk_i;

    tof_collector #(.NUM_CH(NUM_CH), .TS_W(TS_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .tx_start_i       (tx_start_i),
        .time_cnt_i       (time_cnt_i),
        .ch_valid_i       (ch_valid_i),
        .ch_stamp_i       (ch_stamp_i),
        .frame_valid_o    (frame_valid_o),
        .frame_ready_i    (frame_ready_i),
        .frame_tof_o      (frame_tof_o),
        .frame_hit_mask_o (frame_hit_mask_o),
        .frame_timeout_o  (frame_timeout_o),
        .busy_o           (busy_o),
        .overrun_o        (overrun_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: listening window / frame held / idle, per-channel first-hit results.
    bit              m_listen, m_hold, m_to, m_ovr;
    logic [TS_W-1:0] m_t0;
    logic [TS_W-1:0] m_tof [NUM_CH];
    bit [NUM_CH-1:0] m_hit, m_prev;

    task automatic model_reset();
        m_listen = 0; m_hold = 0; m_to = 0; m_ovr = 0; m_t0 = '0;
        m_hit = '0; m_prev = '0;
        for (int i = 0; i < NUM_CH; i++) m_tof[i] = '0;
    endtask

    task automatic model_edge();
        bit [NUM_CH-1:0] rose;
        logic [TS_W-1:0] el;
        bit              ovr_n;
        rose  = ch_valid_i & ~m_prev;
        ovr_n = tx_start_i && (m_listen || m_hold);
        if (m_hold) begin
            if (frame_ready_i) m_hold = 0;
        end else if (m_listen) begin
            for (int i = 0; i < NUM_CH; i++)
                if (rose[i] && !m_hit[i]) begin
                    m_hit[i] = 1;
                    m_tof[i] = ch_stamp_i[i*TS_W +: TS_W] - m_t0;
                end
            el = time_cnt_i - m_t0;
            if (&m_hit) begin
                m_listen = 0; m_hold = 1; m_to = 0;
            end else if (el >= TIMEOUT) begin
                m_listen = 0; m_hold = 1; m_to = 1;
            end
        end else if (tx_start_i) begin
            m_listen = 1; m_t0 = time_cnt_i; m_hit = '0; m_to = 0;
            for (int i = 0; i < NUM_CH; i++) m_tof[i] = '0;
        end
        m_prev = ch_valid_i;
        m_ovr  = ovr_n;
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_CH*TS_W-1:0] exp_tof;
        for (int i = 0; i < NUM_CH; i++) exp_tof[i*TS_W +: TS_W] = m_tof[i];
        check_eq({tag, ".valid"},   frame_valid_o,    m_hold);
        check_eq({tag, ".busy"},    busy_o,           m_listen || m_hold);
        check_eq({tag, ".overrun"}, overrun_o,        m_ovr);
        check_eq({tag, ".mask"},    frame_hit_mask_o, m_hit);
        check_eq({tag, ".timeout"}, frame_timeout_o,  m_to);
        check_eq({tag, ".tof"},     frame_tof_o,      exp_tof);
    endtask

    task automatic cycle(input string tag = "cyc");
        @(posedge clk_i);
        model_edge();
        #1;
        check_outputs(tag);
        time_cnt_i = time_cnt_i + 1;
        tx_start_i = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic [TS_W-1:0] s);
        ch_valid_i[i] = 1'b1;
        ch_stamp_i[i*TS_W +: TS_W] = s;
    endtask

    function automatic logic [TS_W-1:0] tof_of(input int i);
        return frame_tof_o[i*TS_W +: TS_W];
    endfunction

    task automatic accept();
        frame_ready_i = 1'b1;
        cycle("acc");
        check_eq("acc.valid_low", frame_valid_o, 1'b0);
        check_eq("acc.busy_low",  busy_o,        1'b0);
        frame_ready_i = 1'b0;
        ch_valid_i = '0;
        cycle("acc");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TS_W-1:0] t0, t_close;
        int              n, ovr_cnt;

        model_reset();
        #1 rst_ni = 1'b0;
        #1;
        check_eq("rst.valid", frame_valid_o, 1'b0);
        check_eq("rst.busy",  busy_o,        1'b0);
        check_eq("rst.tof",   frame_tof_o,   '0);
        check_eq("rst.mask",  frame_hit_mask_o, '0);
        check_eq("rst.to",    frame_timeout_o, 1'b0);
        check_eq("rst.ovr",   overrun_o,     1'b0);
        @(posedge clk_i); @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // 1: all channels fire in turn
        time_cnt_i = 100; tx_start_i = 1'b1; cycle("t1");
        set_ch(0, 150); cycle("t1");
        set_ch(1, 170); cycle("t1");
        set_ch(2, 130); cycle("t1");
        check_eq("t1.valid_before_last", frame_valid_o, 1'b0);
        set_ch(3, 200); cycle("t1");
        check_eq("t1.valid", frame_valid_o, 1'b1);
        check_eq("t1.tof0", tof_of(0), 50);
        check_eq("t1.tof1", tof_of(1), 70);
        check_eq("t1.tof2", tof_of(2), 30);
        check_eq("t1.tof3", tof_of(3), 100);
        check_eq("t1.mask", frame_hit_mask_o, 4'b1111);
        check_eq("t1.to",   frame_timeout_o, 1'b0);
        accept();

        // 2: timeout with ch0 and ch2 only
        time_cnt_i = 1000; tx_start_i = 1'b1; cycle("t2");
        set_ch(0, 1040); cycle("t2");
        set_ch(2, 1090); cycle("t2");
        time_cnt_i = 60990;
        n = 0;
        do begin
            t_close = time_cnt_i;
            cycle("t2");
            n++;
        end while (!frame_valid_o && n < 50);
        check_eq("t2.valid", frame_valid_o, 1'b1);
        check_eq("t2.close_time", t_close, 61000);
        check_eq("t2.mask", frame_hit_mask_o, 4'b0101);
        check_eq("t2.tof", frame_tof_o, {32'd0, 32'd90, 32'd0, 32'd40});
        check_eq("t2.to",  frame_timeout_o, 1'b1);
        accept();

        // 3: counter wrap between emission and hits
        time_cnt_i = 32'hFFFF_FFF0; tx_start_i = 1'b1; cycle("t3");
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 32'h0000_0010);
        cycle("t3");
        check_eq("t3.valid", frame_valid_o, 1'b1);
        check_eq("t3.tof", frame_tof_o, {4{32'd32}});
        check_eq("t3.to",  frame_timeout_o, 1'b0);

        // 4: backpressure with an emission during the hold
        ovr_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) tx_start_i = 1'b1;
            cycle("t4");
            if (overrun_o) ovr_cnt++;
        end
        check_eq("t4.ovr_cnt", ovr_cnt, 1);
        check_eq("t4.tof_held", frame_tof_o, {4{32'd32}});
        check_eq("t4.mask_held", frame_hit_mask_o, 4'b1111);
        frame_ready_i = 1'b1;
        cycle("t4");
        check_eq("t4.valid_low", frame_valid_o, 1'b0);
        check_eq("t4.busy_low",  busy_o, 1'b0);
        frame_ready_i = 1'b0;

        // 5: channel high at arm time, and first-hit-only
        ch_valid_i = 4'b0010; cycle("t5");
        t0 = time_cnt_i; tx_start_i = 1'b1; cycle("t5");
        set_ch(0, t0 + 5); cycle("t5");
        cycle("t5");
        check_eq("t5.ch1_not_hit", frame_hit_mask_o[1], 1'b0);
        ch_valid_i[1] = 1'b0; cycle("t5");
        set_ch(1, t0 + 25); cycle("t5");
        ch_valid_i[0] = 1'b0; cycle("t5");
        set_ch(0, t0 + 99); cycle("t5");
        check_eq("t5.tof1", tof_of(1), 25);
        check_eq("t5.tof0_first", tof_of(0), 5);
        check_eq("t5.mask", frame_hit_mask_o, 4'b0011);
        set_ch(2, t0 + 7); set_ch(3, t0 + 8); cycle("t5");
        check_eq("t5.valid", frame_valid_o, 1'b1);
        check_eq("t5.tof", frame_tof_o, {32'd8, 32'd7, 32'd25, 32'd5});
        accept();

        // 6: asynchronous reset mid-listen
        tx_start_i = 1'b1; cycle("t6");
        set_ch(0, time_cnt_i + 3); cycle("t6");
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check_eq("t6.rst_busy",  busy_o, 1'b0);
        check_eq("t6.rst_mask",  frame_hit_mask_o, '0);
        check_eq("t6.rst_tof",   frame_tof_o, '0);
        check_eq("t6.rst_valid", frame_valid_o, 1'b0);
        @(posedge clk_i); @(posedge clk_i);
        #2 rst_ni = 1'b1;
        cycle("t6");
        ch_valid_i = '0; cycle("t6");
        t0 = time_cnt_i; tx_start_i = 1'b1; cycle("t6");
        for (int i = 0; i < NUM_CH; i++) set_ch(i, t0 + 32'(i + 1));
        cycle("t6");
        check_eq("t6.valid", frame_valid_o, 1'b1);
        check_eq("t6.tof", frame_tof_o, {32'd4, 32'd3, 32'd2, 32'd1});
        check_eq("t6.to", frame_timeout_o, 1'b0);
        accept();

        // randomized traffic
        time_cnt_i = $urandom;
        for (int r = 0; r < 3000; r++) begin
            ch_valid_i = ch_valid_i ^ 4'($urandom & $urandom);
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 1) == 0)
                    ch_stamp_i[i*TS_W +: TS_W] = time_cnt_i - 32'($urandom_range(0, 5000));
                else
                    ch_stamp_i[i*TS_W +: TS_W] = $urandom;
            tx_start_i    = ($urandom_range(0, 9) == 0);
            frame_ready_i = $urandom_range(0, 1);
            if ($urandom_range(0, 49) == 0)
                time_cnt_i = time_cnt_i + 32'($urandom_range(0, 70000));
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tof_collector.md
Name: tof_collector

Overview:
- Sits directly downstream of the per-receiver trigger capture stages.
- On each ultrasonic emission (tx_start), it records the transmit time and collects the first timestamp from each receiver channel.
- It converts each timestamp into a time-of-flight relative to the emission and presents one frame per emission to the triangulation solver over a valid/ready handshake.
- A timeout closes the frame when one or more receivers never fire.

Parameters:
- NUM_CH, 4, number of receiver channels.
- TS_W, 32, timestamp and time-of-flight width in ticks.
- TIMEOUT, 60000, maximum listening window in time_cnt ticks after tx_start.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_start  in  1  one-cycle pulse marking an emission.
- time_cnt  in  TS_W  free-running tick counter; the same counter feeds the trigger stages.
- ch_valid  in  NUM_CH  per-channel capture-enable level from the trigger stages.
- ch_stamp  in  NUM_CH*TS_W  per-channel captured timestamps, channel i in bits [i*TS_W +: TS_W].
- frame_valid  out  1  frame available.
- frame_ready  in  1  consumer accepts frame.
- frame_tof  out  NUM_CH*TS_W  per-channel time-of-flight, same packing as ch_stamp.
- frame_hit_mask  out  NUM_CH  bit i set if channel i fired within the window.
- frame_timeout  out  1  frame was closed by timeout, not by all channels firing.
- busy  out  1  high in ARMED and OUTPUT.
- overrun  out  1  one-cycle pulse when tx_start arrives while busy.

Behaviour:
- Reset (reset=0, async): the following clear to 0:
  - state=IDLE; t0; hit register; tof registers; frame_valid, frame_timeout, busy, overrun; ch_valid_d.
- Edge detect:
  - ch_valid_d <= ch_valid every cycle, in every state.
  - ch_rise[i] = ch_valid[i] & ~ch_valid_d[i].
  - A channel already high at arm time is not a hit until it falls and rises again.
- IDLE:
  - tx_start=1: t0 <= time_cnt; hits and tofs cleared; state -> ARMED.
  - ch_rise in the same cycle as tx_start is ignored.
- ARMED:
  - For each i with ch_rise[i] and hit[i]=0: hit[i] <= 1 and tof[i] <= ch_stamp[i] - t0 (modulo 2^TS_W, so counter wrap is handled).
  - Later rises on a hit channel are ignored (first-hit only).
  - Let next_hit = hit | ch_rise. If next_hit is all ones: state -> OUTPUT, frame_timeout <= 0, frame_valid <= 1 on the same edge as the last hit is registered.
  - Otherwise, if (time_cnt - t0) mod 2^TS_W >= TIMEOUT: state -> OUTPUT, frame_timeout <= 1, frame_valid <= 1. Rises in that same cycle are still recorded.
  - If all channels hit in the same cycle as timeout, then frame_timeout = 0 (all-hit wins).
- OUTPUT:
  - frame_valid=1; frame_tof, frame_hit_mask and frame_timeout are held stable.
  - On frame_valid & frame_ready: frame_valid <= 0; state -> IDLE.
  - Handshake latency: a new tx_start is accepted at the earliest one cycle after acceptance.
- Unhit channels report tof = 0 with mask bit 0.
- tx_start while state != IDLE: ignored, overrun pulses for 1 cycle, and the current frame is unaffected.
- Reset mid-frame: the frame is discarded and frame_valid drops immediately.
- busy = (state != IDLE).

Decomposition:
- Shared package tof_pkg holds:
  - state encoding localparams: IDLE=2'd0, ARMED=2'd1, OUTPUT=2'd2;
  - default TS_W and TIMEOUT constants;
  - channel-slice helper macro/function for [i*TS_W +: TS_W].
- One natural sub-module, tof_channel: per-channel rise detector, first-hit latch and tof subtractor, instantiated NUM_CH times via generate.
- The FSM, timeout compare and handshake stay in tof_collector.

Test Plan:
1. tx_start at time_cnt=100; channels 0..3 rise with stamps 150, 170, 130, 200 -> frame_valid on the edge of the ch3 hit; tof = 50, 70, 30, 100; mask = 4'b1111; timeout = 0.
2. tx_start at 1000; only ch0 (stamp 1040) and ch2 (stamp 1090) fire; TIMEOUT=60000 -> frame at time_cnt = 61000; mask = 4'b0101; tof = 40, 0, 90, 0; timeout = 1.
3. Wrap: tx_start at time_cnt=32'hFFFF_FFF0; all channels stamp 32'h0000_0010 -> every tof = 32; timeout = 0.
4. Hold frame_ready=0 for 20 cycles with a second tx_start mid-hold -> frame outputs stable, overrun pulses once; frame_ready=1 -> frame_valid falls next edge, busy falls.
5. ch1 high before tx_start and held high -> ch1 is not hit; ch1 drops and rises at stamp t0+25 -> tof1 = 25. A second ch0 rise does not overwrite the first tof0.
6. Assert reset=0 asynchronously mid-ARMED -> all outputs 0 immediately. After release, a fresh tx_start produces a correct frame with no stale hits.
